// File: rtl/sirv_gnrl_rrarb_lock.sv
`default_nettype none
// ============================================================================
// Module   : sirv_gnrl_rrarb_lock
// Brief    : Round-robin arbiter sharing one valid/ready channel among N
//            requesters, with a lock that keeps multi-beat bursts atomic and
//            keeps a stalled grant from being stolen.
// Revision : 1.0 - initial release
// ============================================================================
module sirv_gnrl_rrarb_lock #(
  parameter int N   = 4,
  parameter int IDW = 2,
  parameter int DW  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    i_vld,
  output logic [N-1:0]    i_rdy,
  input  logic [N*DW-1:0] i_dat,
  input  logic [N-1:0]    i_last,
  output logic            o_vld,
  input  logic            o_rdy,
  output logic [DW-1:0]   o_dat,
  output logic            o_last,
  output logic [IDW-1:0]  o_id
);

  typedef enum logic [0:0] {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } st_e;

  st_e            r_st_q;
  st_e            w_st_d;
  logic [IDW-1:0] r_ptr_q;
  logic [IDW-1:0] w_ptr_d;
  logic [IDW-1:0] r_lid_q;
  logic [IDW-1:0] w_lid_d;

  logic           w_sel_ok;   // some requester is selected
  logic [IDW-1:0] w_sel;
  logic           w_sel_vld;  // i_vld of the selected requester
  logic [DW-1:0]  w_sel_dat;
  logic           w_sel_last;
  logic [IDW-1:0] w_sel_inc;
  logic           w_hs;

  // Pick the requester: the locked one in LOCK, otherwise the valid one
  // closest to ptr in round-robin order (smallest forward distance).
  always_comb begin
    int v_dist;
    int v_best;
    w_sel_ok = 1'b0;
    w_sel    = '0;
    v_dist   = 0;
    v_best   = N;
    if (r_st_q == ST_LOCK) begin
      w_sel_ok = 1'b1;
      w_sel    = r_lid_q;
    end else begin
      for (int k = 0; k < N; k++) begin
        v_dist = (k + N - int'(r_ptr_q)) % N;
        if (i_vld[k] && (v_dist < v_best)) begin
          v_best   = v_dist;
          w_sel_ok = 1'b1;
          w_sel    = IDW'(k);
        end
      end
    end
  end

  // Mux the selected requester's channel fields.
  always_comb begin
    w_sel_vld  = 1'b0;
    w_sel_dat  = '0;
    w_sel_last = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (w_sel == IDW'(k)) begin
        w_sel_vld  = i_vld[k];
        w_sel_dat  = i_dat[k*DW +: DW];
        w_sel_last = i_last[k];
      end
    end
  end

  // Drive the downstream channel and the one-hot ready; reset masks both
  // combinationally so nothing is accepted while rst_n is low.
  always_comb begin
    o_vld  = rst_n & w_sel_ok & w_sel_vld;
    o_dat  = o_vld ? w_sel_dat : '0;
    o_last = o_vld ? w_sel_last : 1'b0;
    o_id   = o_vld ? w_sel : '0;
    w_hs   = o_vld & o_rdy;
    i_rdy  = '0;
    for (int k = 0; k < N; k++) begin
      i_rdy[k] = w_hs & (w_sel == IDW'(k));
    end
  end

  // Next lock state and round-robin pointer; ptr only moves on a last beat.
  always_comb begin
    w_sel_inc = (w_sel == IDW'(N - 1)) ? '0 : (w_sel + 1'b1);
    w_st_d    = r_st_q;
    w_ptr_d   = r_ptr_q;
    w_lid_d   = r_lid_q;
    if (r_st_q == ST_ARB) begin
      if (o_vld) begin
        if (w_hs && o_last) begin
          w_ptr_d = w_sel_inc;
        end else begin
          // Stalled grant or first beat of a burst: pin the selection.
          w_st_d  = ST_LOCK;
          w_lid_d = w_sel;
        end
      end
    end else begin
      if (w_hs && o_last) begin
        w_st_d  = ST_ARB;
        w_ptr_d = w_sel_inc;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_st_q  <= ST_ARB;
      r_ptr_q <= '0;
      r_lid_q <= '0;
    end else begin
      r_st_q  <= w_st_d;
      r_ptr_q <= w_ptr_d;
      r_lid_q <= w_lid_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sirv_gnrl_rrarb_lock.sv
`default_nettype none
// ============================================================================
// Module   : tb_sirv_gnrl_rrarb_lock
// Brief    : Directed vector bench for the round-robin lock arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sirv_gnrl_rrarb_lock;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int DW  = 32;
  localparam int NV  = 22;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    i_vld;
  logic [N-1:0]    i_rdy;
  logic [N*DW-1:0] i_dat;
  logic [N-1:0]    i_last;
  logic            o_vld;
  logic            o_rdy;
  logic [DW-1:0]   o_dat;
  logic            o_last;
  logic [IDW-1:0]  o_id;

  int n_vec;
  int n_err;

  typedef struct {
    logic            rst_n;
    logic [N-1:0]    vld;
    logic [N-1:0]    last;
    logic            rdy;
    logic [N*DW-1:0] dat;
    logic            e_vld;
    logic [IDW-1:0]  e_id;
    logic [N-1:0]    e_rdy;
    logic [DW-1:0]   e_dat;
    logic            e_last;
  } vec_t;

  vec_t tbl [NV];

  sirv_gnrl_rrarb_lock #(.N(N), .IDW(IDW), .DW(DW)) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_vld  (i_vld),
    .i_rdy  (i_rdy),
    .i_dat  (i_dat),
    .i_last (i_last),
    .o_vld  (o_vld),
    .o_rdy  (o_rdy),
    .o_dat  (o_dat),
    .o_last (o_last),
    .o_id   (o_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Requesters 0 and 2 always carry 0xA0 / 0xA2; 1 and 3 are per-vector.
  function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [3:0] l,
                              input logic rd, input logic [31:0] d1, input logic [31:0] d3,
                              input logic ev, input logic [1:0] eid, input logic [3:0] erd,
                              input logic [31:0] ed, input logic el);
    vec_t t;
    t.rst_n  = r;
    t.vld    = v;
    t.last   = l;
    t.rdy    = rd;
    t.dat    = {d3, 32'hA2, d1, 32'hA0};
    t.e_vld  = ev;
    t.e_id   = eid;
    t.e_rdy  = erd;
    t.e_dat  = ed;
    t.e_last = el;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp_v);
    end
  endtask

  task automatic chk_all(input string tag, input logic ev, input logic [1:0] eid,
                         input logic [3:0] erd, input logic [31:0] ed, input logic el);
    n_vec++;
    chk({tag, ".o_vld"},  32'(o_vld),  32'(ev));
    chk({tag, ".o_id"},   32'(o_id),   32'(eid));
    chk({tag, ".i_rdy"},  32'(i_rdy),  32'(erd));
    chk({tag, ".o_dat"},  o_dat,       ed);
    chk({tag, ".o_last"}, 32'(o_last), 32'(el));
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    rst_n  = 1'b0;
    i_vld  = '0;
    i_last = '0;
    i_dat  = '0;
    o_rdy  = 1'b0;

    // reset held two cycles with everything requesting
    tbl[0]  = mk(0, 4'hF, 4'hF, 1, 32'hA1, 32'hA3, 0, 0, 4'h0, 32'h00, 0);
    tbl[1]  = mk(0, 4'hF, 4'hF, 1, 32'hA1, 32'hA3, 0, 0, 4'h0, 32'h00, 0);
    // rotation 0,1,2,3,0
    tbl[2]  = mk(1, 4'hF, 4'hF, 1, 32'hA1, 32'hA3, 1, 0, 4'h1, 32'hA0, 1);
    tbl[3]  = mk(1, 4'hF, 4'hF, 1, 32'hA1, 32'hA3, 1, 1, 4'h2, 32'hA1, 1);
    tbl[4]  = mk(1, 4'hF, 4'hF, 1, 32'hA1, 32'hA3, 1, 2, 4'h4, 32'hA2, 1);
    tbl[5]  = mk(1, 4'hF, 4'hF, 1, 32'hA1, 32'hA3, 1, 3, 4'h8, 32'hA3, 1);
    tbl[6]  = mk(1, 4'hF, 4'hF, 1, 32'hA1, 32'hA3, 1, 0, 4'h1, 32'hA0, 1);
    // bring ptr back to 0 via req3
    tbl[7]  = mk(1, 4'h8, 4'hF, 1, 32'hA1, 32'hA3, 1, 3, 4'h8, 32'hA3, 1);
    // stalled grant to req2, req0 arrives but cannot steal it
    tbl[8]  = mk(1, 4'h4, 4'hF, 0, 32'hA1, 32'hA3, 1, 2, 4'h0, 32'hA2, 1);
    tbl[9]  = mk(1, 4'h5, 4'hF, 0, 32'hA1, 32'hA3, 1, 2, 4'h0, 32'hA2, 1);
    tbl[10] = mk(1, 4'h5, 4'hF, 1, 32'hA1, 32'hA3, 1, 2, 4'h4, 32'hA2, 1);
    tbl[11] = mk(1, 4'h1, 4'hF, 1, 32'hA1, 32'hA3, 1, 0, 4'h1, 32'hA0, 1);
    // req1 burst with a gap after beat 1; req0/req2 kept waiting
    tbl[12] = mk(1, 4'h7, 4'hD, 1, 32'h11, 32'hA3, 1, 1, 4'h2, 32'h11, 0);
    tbl[13] = mk(1, 4'h5, 4'hD, 1, 32'h11, 32'hA3, 0, 0, 4'h0, 32'h00, 0);
    tbl[14] = mk(1, 4'h7, 4'hD, 1, 32'h12, 32'hA3, 1, 1, 4'h2, 32'h12, 0);
    tbl[15] = mk(1, 4'h7, 4'hF, 1, 32'h13, 32'hA3, 1, 1, 4'h2, 32'h13, 1);
    tbl[16] = mk(1, 4'h5, 4'hF, 1, 32'hA1, 32'hA3, 1, 2, 4'h4, 32'hA2, 1);
    // req3 locks on beat 1 of 4, reset drops the lock
    tbl[17] = mk(1, 4'h9, 4'h7, 1, 32'hA1, 32'h31, 1, 3, 4'h8, 32'h31, 0);
    tbl[18] = mk(0, 4'h9, 4'h7, 1, 32'hA1, 32'h31, 0, 0, 4'h0, 32'h00, 0);
    tbl[19] = mk(1, 4'h9, 4'h7, 1, 32'hA1, 32'h31, 1, 0, 4'h1, 32'hA0, 1);
    tbl[20] = mk(1, 4'h8, 4'h7, 1, 32'hA1, 32'h32, 1, 3, 4'h8, 32'h32, 0);
    tbl[21] = mk(1, 4'h0, 4'h7, 1, 32'hA1, 32'h32, 0, 0, 4'h0, 32'h00, 0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst_n  = tbl[i].rst_n;
      i_vld  = tbl[i].vld;
      i_last = tbl[i].last;
      o_rdy  = tbl[i].rdy;
      i_dat  = tbl[i].dat;
      #1;
      chk_all($sformatf("vec%0d", i), tbl[i].e_vld, tbl[i].e_id, tbl[i].e_rdy,
              tbl[i].e_dat, tbl[i].e_last);
    end

    // Reset masks outputs combinationally, before any clock edge.
    @(negedge clk);
    rst_n  = 1'b1;
    i_vld  = 4'hF;
    i_last = 4'hF;
    o_rdy  = 1'b1;
    i_dat  = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    #1;
    chk_all("lock_before_rst", 1, 3, 4'h8, 32'hA3, 1);
    rst_n = 1'b0;
    #1;
    chk_all("rst_comb", 0, 0, 4'h0, 32'h0, 0);

    // Gapless 3-beat burst from req0 takes exactly 3 cycles, then req1.
    @(negedge clk);
    rst_n  = 1'b1;
    i_vld  = 4'h3;
    i_last = 4'hE;
    #1;
    chk_all("burst_b0", 1, 0, 4'h1, 32'hA0, 0);
    @(negedge clk);
    #1;
    chk_all("burst_b1", 1, 0, 4'h1, 32'hA0, 0);
    @(negedge clk);
    i_last = 4'hF;
    #1;
    chk_all("burst_b2", 1, 0, 4'h1, 32'hA0, 1);
    @(negedge clk);
    i_vld = 4'h2;
    #1;
    chk_all("after_burst", 1, 1, 4'h2, 32'hA1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
